// File: rtl/button_event_decoder_pkg.sv
// Shared state encoding and elaboration helpers for the button event decoder.
package button_event_decoder_pkg;

  typedef enum logic [1:0] {
    ST_LOCKOUT   = 2'd0,
    ST_IDLE      = 2'd1,
    ST_PRESSED   = 2'd2,
    ST_LONG_HELD = 2'd3
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle press/release/click/long-press/repeat events.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 2_500_000,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  output logic held,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_click,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int unsigned      CNT_W      = $clog2(max_u(LONG_CYCLES, REPEAT_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] LONG_CNT   = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] REPEAT_CNT = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

  state_e           state_r;
  state_e           next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] next_cnt_s;

  logic held_s, press_s, release_s, short_s, long_s, repeat_s;
  logic held_r, press_r, release_r, short_r, long_r, repeat_r;

  // State and hold-time counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_LOCKOUT;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= next_cnt_s;
    end
  end

  // Next-state and counter update; a sampled release always beats a due long/repeat
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    case (state_r)
      ST_LOCKOUT: begin
        if (!btn_level) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_LOCKOUT;
        end
      end
      ST_IDLE: begin
        if (btn_level) begin
          next_state_s = ST_PRESSED;
          next_cnt_s   = CNT_ONE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_PRESSED: begin
        if (!btn_level) begin
          next_state_s = ST_IDLE;
        end else if (cnt_r == LONG_CNT) begin
          next_state_s = ST_LONG_HELD;
          next_cnt_s   = CNT_ONE;
        end else begin
          next_cnt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_LONG_HELD: begin
        if (!btn_level) begin
          next_state_s = ST_IDLE;
        end else if (cnt_r == REPEAT_CNT) begin
          // Reload when repeating, otherwise park at the limit so it never wraps
          if (REPEAT_EN) begin
            next_cnt_s = CNT_ONE;
          end else begin
            next_cnt_s = cnt_r;
          end
        end else begin
          next_cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        next_state_s = ST_LOCKOUT;
        next_cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Event decode from current state and sampled level
  always_comb begin
    press_s   = 1'b0;
    release_s = 1'b0;
    short_s   = 1'b0;
    long_s    = 1'b0;
    repeat_s  = 1'b0;
    case (state_r)
      ST_LOCKOUT: begin
        press_s = 1'b0;
      end
      ST_IDLE: begin
        if (btn_level) begin
          press_s = 1'b1;
        end else begin
          press_s = 1'b0;
        end
      end
      ST_PRESSED: begin
        if (!btn_level) begin
          release_s = 1'b1;
          short_s   = 1'b1;
        end else if (cnt_r == LONG_CNT) begin
          long_s = 1'b1;
        end else begin
          long_s = 1'b0;
        end
      end
      ST_LONG_HELD: begin
        if (!btn_level) begin
          release_s = 1'b1;
        end else if (REPEAT_EN && (cnt_r == REPEAT_CNT)) begin
          repeat_s = 1'b1;
        end else begin
          repeat_s = 1'b0;
        end
      end
      default: begin
        press_s = 1'b0;
      end
    endcase
    held_s = btn_level && (state_r != ST_LOCKOUT);
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_r    <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      short_r   <= 1'b0;
      long_r    <= 1'b0;
      repeat_r  <= 1'b0;
    end else begin
      held_r    <= held_s;
      press_r   <= press_s;
      release_r <= release_s;
      short_r   <= short_s;
      long_r    <= long_s;
      repeat_r  <= repeat_s;
    end
  end

  assign held          = held_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;
  assign short_click   = short_r;
  assign long_press    = long_r;
  assign repeat_pulse  = repeat_r;

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench: hold-time model compared every cycle, plus literal event timing checks.
module tb_button_event_decoder;

  localparam int LONG = 8;
  localparam int REP  = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic btn;
  logic held1, press1, rel1, short1, long1, rep1;
  logic held2, press2, rel2, short2, long2, rep2;

  int n_err    = 0;
  int n_checks = 0;
  bit chk_en   = 1'b0;

  typedef struct packed {
    bit locked;
    bit pressed;
    bit long_fired;
    int hold;
    bit held;
    bit press;
    bit rel;
    bit shortc;
    bit longp;
    bit rep;
  } model_t;

  model_t m1, m2;

  button_event_decoder #(.LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .btn_level(btn), .held(held1), .press_pulse(press1),
    .release_pulse(rel1), .short_click(short1), .long_press(long1), .repeat_pulse(rep1)
  );

  button_event_decoder #(.LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b0)) dut_nr (
    .clk(clk), .rst_n(rst_n), .btn_level(btn), .held(held2), .press_pulse(press2),
    .release_pulse(rel2), .short_click(short2), .long_press(long2), .repeat_pulse(rep2)
  );

  always #5 clk = ~clk;

  function automatic model_t reset_model();
    model_t r;
    r = '0;
    r.locked = 1'b1;
    return r;
  endfunction

  // Hold time counts edges since the accepted press; events follow from it arithmetically
  function automatic model_t step(model_t m, bit b, bit rep_en);
    model_t n;
    n = m;
    n.press = 1'b0; n.rel = 1'b0; n.shortc = 1'b0; n.longp = 1'b0; n.rep = 1'b0;
    n.held = b && !m.locked;
    if (m.locked) begin
      if (!b) n.locked = 1'b0;
    end else if (!m.pressed) begin
      if (b) begin
        n.pressed = 1'b1; n.hold = 0; n.long_fired = 1'b0; n.press = 1'b1;
      end
    end else if (!b) begin
      n.pressed = 1'b0; n.rel = 1'b1; n.shortc = !m.long_fired;
    end else begin
      n.hold = m.hold + 1;
      if (n.hold == LONG) begin
        n.longp = 1'b1; n.long_fired = 1'b1;
      end else if (rep_en && n.hold > LONG && ((n.hold - LONG) % REP) == 0) begin
        n.rep = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 <= reset_model();
      m2 <= reset_model();
    end else begin
      m1 <= step(m1, btn, 1'b1);
      m2 <= step(m2, btn, 1'b0);
    end
  end

  task automatic cmp(input string name, input logic got, input bit exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("held",    held1,  m1.held);   cmp("press",    press1, m1.press);
      cmp("release", rel1,   m1.rel);    cmp("short",    short1, m1.shortc);
      cmp("long",    long1,  m1.longp);  cmp("repeat",   rep1,   m1.rep);
      cmp("nr_held", held2,  m2.held);   cmp("nr_press", press2, m2.press);
      cmp("nr_rel",  rel2,   m2.rel);    cmp("nr_short", short2, m2.shortc);
      cmp("nr_long", long2,  m2.longp);  cmp("nr_rep",   rep2,   m2.rep);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      btn = 1'b0;
    end
  endtask

  // Tick i drives the level sampled at edge i and first observes the events labelled @i
  task automatic run_case(input int n_high, input int n_total, input bit use_m2,
                          input int press_at, input int long_at, input int rel_at,
                          input int short_at, input int rep_first, input int rep_last);
    model_t mm;
    bit rep_exp;
    for (int i = 0; i < n_total; i++) begin
      @(negedge clk); #1;
      mm = use_m2 ? m2 : m1;
      rep_exp = (rep_first >= 0) && (i >= rep_first) && (i <= rep_last) && (((i - rep_first) % REP) == 0);
      cmp("lit_press", mm.press,  i == press_at);
      cmp("lit_long",  mm.longp,  i == long_at);
      cmp("lit_rel",   mm.rel,    i == rel_at);
      cmp("lit_short", mm.shortc, i == short_at);
      cmp("lit_rep",   mm.rep,    rep_exp);
      btn = (i < n_high);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    cmp("reset_held",  held1,  1'b0);
    cmp("reset_press", press1, 1'b0);
    cmp("reset_long",  long1,  1'b0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    idle(3);

    run_case(4, 8, 1'b0, 1, -1, 5, 5, -1, -1);
    idle(3);
    run_case(20, 24, 1'b0, 1, 9, 21, -1, 12, 18);
    idle(3);
    run_case(8, 12, 1'b0, 1, -1, 9, 9, -1, -1);
    idle(3);
    run_case(9, 12, 1'b0, 1, 9, 10, -1, -1, -1);
    idle(3);
    run_case(30, 34, 1'b1, 1, 9, 31, -1, -1, -1);
    idle(3);

    // Button held through reset release is locked out until it is let go
    @(negedge clk); #1;
    rst_n = 1'b0;
    btn   = 1'b1;
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      cmp("lock_press", m1.press, 1'b0);
      cmp("lock_held",  m1.held,  1'b0);
    end
    btn = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    btn = 1'b1;
    @(negedge clk); #1;
    cmp("lock_repress", m1.press, 1'b1);
    cmp("lock_reheld",  m1.held,  1'b1);
    idle(4);

    // Reset pulse in the middle of a long hold
    run_case(12, 12, 1'b0, 1, 9, -1, -1, -1, -1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    cmp("async_held",  held1,  1'b0);
    cmp("async_press", press1, 1'b0);
    cmp("async_rel",   rel1,   1'b0);
    cmp("async_short", short1, 1'b0);
    cmp("async_long",  long1,  1'b0);
    cmp("async_rep",   rep1,   1'b0);
    cmp("async_nr",    held2,  1'b0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      cmp("post_rst_press", m1.press, 1'b0);
      cmp("post_rst_rep",   m1.rep,   1'b0);
      cmp("post_rst_held",  m1.held,  1'b0);
    end
    idle(2);
    run_case(3, 6, 1'b0, 1, -1, 4, 4, -1, -1);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
